if_fetch_queue: RTL

Parametrised instruction-fetch unit with a DEPTH-entry fetch queue between the memory controller and decode. It owns the fetch PC, keeps one outstanding request to the memory controller, buffers returned instructions with their PCs, and flushes cleanly on a redirect even while a request is in flight. It replaces the single-slot combinational fetch stage.

---
 rtl/if_fetch_queue_pkg.sv | 28 ++
 rtl/if_fetch_queue_fetch_fifo.sv | 81 ++++++++
 rtl/if_fetch_queue.sv | 157 +++++++++++++++
 3 files changed

// File: rtl/if_fetch_queue_pkg.sv
// if_fetch_queue_pkg
//   Shared definitions for the instruction-fetch queue slice: fetch FSM
//   state encodings, the JAL opcode, the sequential PC step and a helper
//   that extracts the J-type immediate.
//   No ports.

package if_fetch_queue_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,  // no request outstanding
        ST_WAIT = 2'd1,  // request outstanding, data will be kept
        ST_DROP = 2'd2   // request outstanding, data will be discarded
    } fetch_state_e;

    localparam logic [6:0] OPCODE_JAL = 7'b1101111;
    localparam int         PC_STEP    = 4;

    // True when the instruction word is a JAL.
    function automatic logic is_jal(input logic [31:0] inst);
        return inst[6:0] == OPCODE_JAL;
    endfunction

    // J-type immediate as a 21-bit two's-complement byte offset.
    function automatic logic [20:0] jal_imm(input logic [31:0] inst);
        return {inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/if_fetch_queue_fetch_fifo.sv
// if_fetch_queue_fetch_fifo
//   DEPTH-entry circular buffer holding fetched {instruction, pc[, pred]}
//   entries. Flush clears the occupancy in one cycle; the head word reads
//   as zero while the buffer is empty.
// Ports
//   clk, rst       clock, synchronous active-high reset
//   en_i           global enable; low freezes all state
//   flush_i        drop every entry (wins over push and pop)
//   push_i         append push_data_i at the tail
//   pop_i          remove the head entry
//   push_data_i    entry to append
//   head_data_o    head entry, zero when empty
//   valid_o        buffer holds at least one entry
//   count_o        number of occupied entries

module if_fetch_queue_fetch_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 64,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en_i,
    input  logic             flush_i,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic [WIDTH-1:0] head_data_o,
    output logic             valid_o,
    output logic [CNT_W-1:0] count_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] head_q;
    logic [PTR_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             full;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign valid_o = (count_q != '0);
    assign do_pop  = pop_i && valid_o;
    assign do_push = push_i && (!full || do_pop);

    // Pointers are PTR_W bits wide and DEPTH is a power of two, so the
    // natural binary wrap gives modulo-DEPTH behaviour.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (en_i) begin
            if (flush_i) begin
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else begin
                if (do_push) tail_q <= tail_q + PTR_W'(1);
                if (do_pop)  head_q <= head_q + PTR_W'(1);
                if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
                else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
            end
        end
    end

    // NOTE: the storage array has no reset; occupancy alone decides which
    // words are meaningful, and empty reads are masked below.
    always_ff @(posedge clk) begin
        if (en_i && !flush_i && do_push) begin
            mem_q[tail_q] <= push_data_i;
        end
    end

    assign head_data_o = valid_o ? mem_q[head_q] : '0;
    assign count_o     = count_q;

endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue
//   Instruction-fetch unit: owns the fetch PC, keeps at most one request
//   outstanding at the memory controller and buffers returned instructions
//   with their PCs in a DEPTH-entry queue for decode. A redirect flushes the
//   queue at once; a request already in flight is allowed to complete and
//   its data is thrown away.
//   Build option: define IFQ_JAL_PREDICT_EN to follow JAL targets at fetch
//   and flag those entries as predicted taken; otherwise fetch is strictly
//   sequential and pred_taken_out is tied low.
// Ports
//   clk, rst            clock, synchronous active-high reset
//   rdy                 global enable; low freezes all state
//   redirect_valid_in   flush queue, restart at redirect_pc_in
//   redirect_pc_in      new fetch PC
//   mc_req_out          request to memory controller (held until ack)
//   mc_addr_out         request address, zero while idle
//   mc_ack_in           one-cycle data-valid pulse for the current request
//   mc_data_in          returned instruction
//   inst_valid_out      queue head valid
//   inst_ready_in       decode accepts head when valid
//   inst_out, pc_out    head instruction and its PC, zero when empty
//   pred_taken_out      head entry was fetched as a taken JAL
//   count_out           occupied queue entries

module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int              ADDR_W   = 32,
    parameter int              INST_W   = 32,
    parameter int              DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    localparam int             CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              redirect_valid_in,
    input  logic [ADDR_W-1:0] redirect_pc_in,
    output logic              mc_req_out,
    output logic [ADDR_W-1:0] mc_addr_out,
    input  logic              mc_ack_in,
    input  logic [INST_W-1:0] mc_data_in,
    output logic              inst_valid_out,
    input  logic              inst_ready_in,
    output logic [INST_W-1:0] inst_out,
    output logic [ADDR_W-1:0] pc_out,
    output logic              pred_taken_out,
    output logic [CNT_W-1:0]  count_out
);

`ifdef IFQ_JAL_PREDICT_EN
    localparam int ENTRY_W = INST_W + ADDR_W + 1;
`else
    localparam int ENTRY_W = INST_W + ADDR_W;
`endif

    fetch_state_e      state_q, state_d;
    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
    logic [ADDR_W-1:0] req_pc_q, req_pc_d;
    logic [ADDR_W-1:0] next_pc;
    logic [ENTRY_W-1:0] push_entry;
    logic [ENTRY_W-1:0] head_entry;
    logic              push;
    logic              pop;

    // The PC following the returned instruction. fetch_pc equals req_pc
    // whenever data is accepted, so req_pc is the base for both paths.
`ifdef IFQ_JAL_PREDICT_EN
    logic        take_jal;
    logic [20:0] j_off;

    assign take_jal   = is_jal(mc_data_in[31:0]);
    assign j_off      = jal_imm(mc_data_in[31:0]);
    assign next_pc    = take_jal ? req_pc_q + {{(ADDR_W-21){j_off[20]}}, j_off}
                                 : req_pc_q + ADDR_W'(PC_STEP);
    assign push_entry = {mc_data_in, req_pc_q, take_jal};
    assign {inst_out, pc_out, pred_taken_out} = head_entry;
`else
    assign next_pc    = req_pc_q + ADDR_W'(PC_STEP);
    assign push_entry = {mc_data_in, req_pc_q};
    assign {inst_out, pc_out} = head_entry;
    assign pred_taken_out     = 1'b0;
`endif

    // Redirect beats a same-cycle dequeue.
    assign pop = inst_ready_in && inst_valid_out && !redirect_valid_in;

    // NOTE: every variable written here gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        req_pc_d   = req_pc_q;
        push       = 1'b0;

        case (state_q)
            ST_IDLE: begin
                // One request at a time and only with a free slot, so the
                // queue can never overflow.
                if (!redirect_valid_in && (count_out < CNT_W'(DEPTH))) begin
                    req_pc_d = fetch_pc_q;
                    state_d  = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (mc_ack_in) begin
                    state_d = ST_IDLE;
                    if (!redirect_valid_in) begin
                        push       = 1'b1;
                        fetch_pc_d = next_pc;
                    end
                end else if (redirect_valid_in) begin
                    // Controller cannot abort; wait out the ack and drop it.
                    state_d = ST_DROP;
                end
            end
            ST_DROP: begin
                if (mc_ack_in) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        if (redirect_valid_in) fetch_pc_d = redirect_pc_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            fetch_pc_q <= RESET_PC;
            req_pc_q   <= '0;
        end else if (rdy) begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            req_pc_q   <= req_pc_d;
        end
    end

    assign mc_req_out  = (state_q != ST_IDLE);
    assign mc_addr_out = mc_req_out ? req_pc_q : '0;

    if_fetch_queue_fetch_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .en_i        (rdy),
        .flush_i     (redirect_valid_in),
        .push_i      (push),
        .pop_i       (pop),
        .push_data_i (push_entry),
        .head_data_o (head_entry),
        .valid_o     (inst_valid_out),
        .count_o     (count_out)
    );

endmodule
